nn_input_sequencer: RTL and testbench

Upstream feeder for the `NN` datapath. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Presents one pair at a time on `NN`'s `input_1`/`input_2` with `enable` held high for a fixed compute window. Captures `final_output`, `total_ovf` and `total_zero` into a result register with its own valid/ready handshake, so a testbench or host can stream back-to-back vectors without hand-timed delays.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/nn_pair_fifo.sv | 47 ++++
 rtl/nn_input_sequencer.sv | 162 ++++++++++++++++
 tb/tb_nn_input_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the NN input sequencer: default operand width,
// sequencer FSM encodings, statistics counter width and a saturating increment.
package nn_pkg;

  localparam int NN_DATAWIDTH = 32;
  localparam int NN_STAT_W    = 16;

  typedef enum logic [1:0] {
    NN_SEQ_IDLE  = 2'd0,
    NN_SEQ_ISSUE = 2'd1,
    NN_SEQ_WAIT  = 2'd2,
    NN_SEQ_DONE  = 2'd3
  } nn_seq_state_e;

  function automatic logic [NN_STAT_W-1:0] nn_sat_inc(
    input logic [NN_STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nn_pair_fifo.sv
// Operand-pair FIFO storing {a,b}; pointers carry a wrap bit for full/empty.
// Ports: clk_i, reset_i, push_i/a_i/b_i, pop_i, a_o/b_o (head), full_o, empty_o.
module nn_pair_fifo #(
  parameter int DATAWIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  input  logic                 pop_i,
  output logic [DATAWIDTH-1:0] a_o,
  output logic [DATAWIDTH-1:0] b_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]            wr_q, rd_q;
  logic [2*DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                   do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign {a_o, b_o} = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= {a_i, b_i};
  end

endmodule

// File: rtl/nn_input_sequencer.sv
// Feeds operand pairs from a FIFO into NN, holds enable for the compute window
// and captures the result behind a valid/ready handshake. Ports: in_* stream,
// nn_* to/from NN, res_* result stream, busy, stat_* (live with NN_SEQ_STATS_EN).
module nn_input_sequencer
  import nn_pkg::*;
#(
  parameter int DATAWIDTH  = NN_DATAWIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int NN_LATENCY = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_a,
  input  logic [DATAWIDTH-1:0] in_b,
  output logic [DATAWIDTH-1:0] nn_input_1,
  output logic [DATAWIDTH-1:0] nn_input_2,
  output logic                 nn_enable,
  output logic                 nn_resetn,
  input  logic [DATAWIDTH-1:0] nn_final_output,
  input  logic                 nn_total_ovf,
  input  logic                 nn_total_zero,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATAWIDTH-1:0] res_data,
  output logic                 res_ovf,
  output logic                 res_zero,
  output logic                 busy,
  output logic [NN_STAT_W-1:0] stat_done,
  output logic [NN_STAT_W-1:0] stat_ovf,
  output logic [NN_STAT_W-1:0] stat_zero
);

  localparam int CW = $clog2(NN_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NN_LATENCY - 2);

  nn_seq_state_e          state_q;
  logic [CW-1:0]          cnt_q;
  logic [DATAWIDTH-1:0]   in1_q, in2_q, res_data_q;
  logic                   en_q, resetn_q;
  logic                   res_valid_q, res_ovf_q, res_zero_q;
  logic [DATAWIDTH-1:0]   head_a, head_b;
  logic                   full, empty, pop, res_hs;

  assign res_hs = res_valid_q && res_ready;

  // DONE pops on the handshake cycle so the next pair issues with no bubble
  assign pop = !empty && ((state_q == NN_SEQ_IDLE) ||
                          (state_q == NN_SEQ_DONE && res_hs));

  nn_pair_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (in_valid),
    .a_i    (in_a),
    .b_i    (in_b),
    .pop_i  (pop),
    .a_o    (head_a),
    .b_o    (head_b),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NN_SEQ_IDLE;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        NN_SEQ_IDLE: begin
          if (pop) begin
            in1_q   <= head_a;
            in2_q   <= head_b;
            en_q    <= 1'b1;
            state_q <= NN_SEQ_ISSUE;
          end
        end
        NN_SEQ_ISSUE: begin
          cnt_q   <= CNT_LOAD;
          state_q <= NN_SEQ_WAIT;
        end
        NN_SEQ_WAIT: begin
          if (cnt_q == '0) begin
            res_data_q  <= nn_final_output;
            res_ovf_q   <= nn_total_ovf;
            res_zero_q  <= nn_total_zero;
            res_valid_q <= 1'b1;
            en_q        <= 1'b0;
            state_q     <= NN_SEQ_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        NN_SEQ_DONE: begin
          if (res_hs) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              in1_q   <= head_a;
              in2_q   <= head_b;
              en_q    <= 1'b1;
              state_q <= NN_SEQ_ISSUE;
            end else begin
              state_q <= NN_SEQ_IDLE;
            end
          end
        end
        default: state_q <= NN_SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    resetn_q <= ~reset;
  end

  assign in_ready   = !full;
  assign nn_input_1 = in1_q;
  assign nn_input_2 = in2_q;
  assign nn_enable  = en_q;
  assign nn_resetn  = resetn_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_ovf    = res_ovf_q;
  assign res_zero   = res_zero_q;
  assign busy       = (state_q != NN_SEQ_IDLE) || !empty;

`ifdef NN_SEQ_STATS_EN
  logic [NN_STAT_W-1:0] stat_done_q, stat_ovf_q, stat_zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_done_q <= '0;
      stat_ovf_q  <= '0;
      stat_zero_q <= '0;
    end else if (res_hs) begin
      stat_done_q <= nn_sat_inc(stat_done_q);
      if (res_ovf_q)  stat_ovf_q  <= nn_sat_inc(stat_ovf_q);
      if (res_zero_q) stat_zero_q <= nn_sat_inc(stat_zero_q);
    end
  end

  assign stat_done = stat_done_q;
  assign stat_ovf  = stat_ovf_q;
  assign stat_zero = stat_zero_q;
`else
  assign stat_done = '0;
  assign stat_ovf  = '0;
  assign stat_zero = '0;
`endif

endmodule

// File: tb/tb_nn_input_sequencer.sv
// Scoreboard bench for nn_input_sequencer with a behavioural NN stand-in
// (saturating signed add, output valid only after the full compute window).
module tb_nn_input_sequencer;

  localparam int DW  = 32;
  localparam int LAT = 12;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          ovf;
    logic          zero;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [DW-1:0] nn_input_1, nn_input_2;
  logic          nn_enable, nn_resetn;
  logic [DW-1:0] nn_final_output;
  logic          nn_total_ovf, nn_total_zero;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_ovf, res_zero, busy;
  logic [15:0]   stat_done, stat_ovf, stat_zero;

  always #5 clk = ~clk;

  nn_input_sequencer #(
    .DATAWIDTH (DW),
    .FIFO_DEPTH(4),
    .NN_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .nn_input_1     (nn_input_1),
    .nn_input_2     (nn_input_2),
    .nn_enable      (nn_enable),
    .nn_resetn      (nn_resetn),
    .nn_final_output(nn_final_output),
    .nn_total_ovf   (nn_total_ovf),
    .nn_total_zero  (nn_total_zero),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_ovf        (res_ovf),
    .res_zero       (res_zero),
    .busy           (busy),
    .stat_done      (stat_done),
    .stat_ovf       (stat_ovf),
    .stat_zero      (stat_zero)
  );

  function automatic res_t nn_model(input logic [DW-1:0] a, b);
    res_t r;
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    r.ovf = s[DW] ^ s[DW-1];
    r.d = r.ovf ? (s[DW] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s[DW-1:0];
    r.zero = (r.d == '0);
    return r;
  endfunction

  // NN stand-in: junk until inputs and enable have been stable long enough
  int            nn_cnt = 0;
  logic [DW-1:0] nn_p1 = '0, nn_p2 = '0;
  res_t          nn_res;

  always @(posedge clk) begin
    if (nn_resetn !== 1'b1 || nn_enable !== 1'b1 ||
        nn_input_1 !== nn_p1 || nn_input_2 !== nn_p2)
      nn_cnt <= 0;
    else if (nn_cnt < 1000)
      nn_cnt <= nn_cnt + 1;
    nn_p1 <= nn_input_1;
    nn_p2 <= nn_input_2;
  end

  assign nn_res          = nn_model(nn_input_1, nn_input_2);
  assign nn_final_output = (nn_cnt >= LAT-2) ? nn_res.d : 32'hA5A5_A5A5;
  assign nn_total_ovf    = (nn_cnt >= LAT-2) ? nn_res.ovf : 1'b1;
  assign nn_total_zero   = (nn_cnt >= LAT-2) ? nn_res.zero : 1'b1;

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, acc_cyc = 0, last_rise = 0, rises = 0;
  bit   gap_en = 0, have_prev = 0;
  logic prev_v = 1'b0;
  res_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // monitor: pops the scoreboard whenever a handshake is about to occur
  always @(negedge clk) begin
    res_t e;
    if (reset !== 1'b1) begin
      if (res_valid === 1'b1 && prev_v !== 1'b1) begin
        rises++;
        if (gap_en && have_prev) chk("gap", 64'(cyc - last_rise), LAT+1);
        last_rise = cyc;
        have_prev = 1;
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("res", {res_data, res_ovf, res_zero}, {e.d, e.ovf, e.zero});
        end
      end
    end
    prev_v = res_valid;
  end

  task automatic push(input logic [DW-1:0] a, b, input res_t e);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (in_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk("push_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      acc_cyc = cyc + 1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain"}, 64'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [DW-1:0] bp_a [6] = '{32'd5, 32'hFFFF_FFFD, 32'd100,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'd123456};
  logic [DW-1:0] bp_b [6] = '{32'd7, 32'd3, 32'hFFFF_FF06,
                              32'd1, 32'hFFFF_FFFF, 32'd654321};
  res_t bp_e [6] = '{'{32'd12, 1'b0, 1'b0},
                     '{32'd0, 1'b0, 1'b1},
                     '{32'hFFFF_FF6A, 1'b0, 1'b0},
                     '{32'h7FFF_FFFF, 1'b1, 1'b0},
                     '{32'h8000_0000, 1'b1, 1'b0},
                     '{32'd777777, 1'b0, 1'b0}};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r0;
    logic [DW-1:0] a, b;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_nn_in", {nn_input_1, nn_input_2}, 0);
    chk("rst_en_resetn", {nn_enable, nn_resetn}, 0);
    chk("rst_res", {res_valid, res_data, res_ovf, res_zero}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stats", {stat_done, stat_ovf, stat_zero}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("resetn_rise", nn_resetn, 1);

    // single vector latency
    res_ready = 1'b1;
    push(32'd0, 32'd0, '{32'd0, 1'b0, 1'b1});
    drain("single");
    chk("latency", 64'(last_rise - acc_cyc), LAT+1);
`ifdef NN_SEQ_STATS_EN
    chk("stat_zero_single", stat_zero, 1);
`endif

    // saturation
    do_reset();
    push(32'd1343146143, 32'd1679362119, '{32'h7FFF_FFFF, 1'b1, 1'b0});
    drain("sat");
`ifdef NN_SEQ_STATS_EN
    chk("stat_ovf_sat", stat_ovf, 1);
    chk("stat_done_sat", stat_done, 1);
`endif

    // backpressure
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i], bp_e[i]);
    @(negedge clk);
    chk("bp_full", in_ready, 0);
    in_valid = 1'b1;
    in_a = bp_a[5];
    in_b = bp_b[5];
    repeat (20) @(negedge clk);
    chk("bp_held", in_ready, 0);
    chk("bp_res_hold", {res_valid, res_data}, {1'b1, bp_e[0].d});
    res_ready = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_release", in_ready, 1);
    exp_q.push_back(bp_e[5]);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain("bp");

    // back-to-back
    do_reset();
    gap_en = 1;
    have_prev = 0;
    for (int i = 0; i < 303; i++) begin
      case (i % 3)
        0: begin
          a = 32'($urandom_range(0, 2000)) - 32'd1000;
          b = 32'($urandom_range(0, 2000)) - 32'd1000;
        end
        1: begin
          a = 32'($urandom_range(32'h4000_0000, 32'h7FFF_FFFF));
          b = 32'($urandom_range(32'h4000_0000, 32'h7FFF_FFFF));
        end
        default: begin
          a = 32'h8000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF));
          b = 32'h8000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF));
        end
      endcase
      push(a, b, nn_model(a, b));
    end
    drain("b2b");
    gap_en = 0;

    // reset mid-WAIT
    do_reset();
    push(32'd11, 32'd22, '{32'd33, 1'b0, 1'b0});
    push(32'd1, 32'd2, '{32'd3, 1'b0, 1'b0});
    push(32'd4, 32'd5, '{32'd9, 1'b0, 1'b0});
    t = 0;
    while (cyc < acc_cyc + 4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_enable", nn_enable, 0);
    reset = 1'b0;
    r0 = rises;
    repeat (3 * (LAT + 1)) @(negedge clk);
    chk("no_stale", 64'(rises - r0), 0);
    chk("idle_busy", busy, 0);

`ifdef NN_SEQ_STATS_EN
    // stats saturation
    do_reset();
    force dut.stat_done_q = 16'hFFFE;
    @(negedge clk);
    release dut.stat_done_q;
    for (int i = 0; i < 3; i++) push(bp_a[i], bp_b[i], bp_e[i]);
    drain("stats");
    chk("stat_done_sat", stat_done, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
